ifu: RTL and testbench

Instruction fetch unit: the producer side of the `inst` interface consumed by the instruction decoder. Holds the fetch PC, issues in-order word requests to instruction memory, buffers returned words with their PCs in a small prefetch FIFO, and presents one instruction per cycle to the decoder under a valid/ready handshake. Redirects from execute (jal, jalr, taken branch) flush the buffer and discard in-flight responses.

---
 rtl/ifu_pkg.sv | 15 +
 rtl/ifu_if.sv | 26 ++
 rtl/ifu_fifo.sv | 51 +++++
 rtl/ifu.sv | 141 ++++++++++++++
 tb/tb_ifu.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional feature macro: IFU_MISALIGN_TRAP_EN (misaligned-redirect trap with HALT state).
package ifu_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_HALT
  } ifu_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/ifu_if.sv
// Fetch-unit bus: instruction-memory request/response, decoder handshake, execute redirect.
// master = fetch unit side, slave = memory/decoder/execute side.
interface ifu_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_val;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign_err;

  modport master (
    output imem_req, imem_addr, inst, inst_pc, inst_val, misalign_err,
    input  imem_gnt, imem_rvalid, imem_rdata, id_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst, inst_pc, inst_val, misalign_err,
    output imem_gnt, imem_rvalid, imem_rdata, id_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with synchronous flush; registered storage, head read combinationally.
// A push into a full FIFO is accepted only together with a pop in the same cycle.
module ifu_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: credit-limited in-order fetch into a prefetch FIFO; grant->inst_val = response cycle + 1.
// Decoder backpressure fills the FIFO and withholds requests; IFU_MISALIGN_TRAP_EN adds the misaligned-redirect HALT trap.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 4
) (
  input logic   clk,
  input logic   rst,
  ifu_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  ifu_state_e  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [31:0] tgt;
  logic        tgt_bad;
  logic        grant, rsp, rsp_keep, pop;
  logic        have_credit;
  logic [CW:0] in_use;

  logic [63:0]   iq_head;
  logic          iq_empty, iq_full;
  logic [CW-1:0] iq_cnt;
  logic [31:0]   pq_head;
  logic          pq_empty, pq_full;
  logic [CW-1:0] pq_cnt;

`ifdef IFU_MISALIGN_TRAP_EN
  logic err_q, err_d;
  assign tgt              = bus.redirect_pc;
  assign tgt_bad          = |bus.redirect_pc[1:0];
  assign bus.misalign_err = err_q;
`else
  logic unused_pc_lsb;
  assign tgt              = {bus.redirect_pc[31:2], 2'b00};
  assign tgt_bad          = 1'b0;
  assign unused_pc_lsb    = ^{bus.redirect_pc[1:0], tgt_bad};
  assign bus.misalign_err = 1'b0;
`endif

  // Credit covers both words in flight (including ones to be dropped) and buffered words.
  assign in_use      = {1'b0, out_q} + {1'b0, iq_cnt};
  assign have_credit = in_use < (CW+1)'(DEPTH);

  assign bus.imem_req  = ~rst & (state_q == ST_RUN) & have_credit & ~bus.redirect;
  assign bus.imem_addr = {fetch_pc_q[31:2], 2'b00};
  assign grant         = bus.imem_req & bus.imem_gnt;
  assign rsp           = bus.imem_rvalid & (out_q != '0);
  assign rsp_keep      = rsp & (drop_q == '0) & ~bus.redirect;

  assign bus.inst_val = ~iq_empty & ~bus.redirect;
  assign bus.inst     = iq_empty ? 32'h0 : iq_head[63:32];
  assign bus.inst_pc  = iq_empty ? 32'h0 : iq_head[31:0];
  assign pop          = bus.inst_val & bus.id_ready;

  ifu_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_inst_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.redirect),
    .push     (rsp_keep),
    .push_dat ({bus.imem_rdata, pq_head}),
    .pop      (pop),
    .pop_dat  (iq_head),
    .full     (iq_full),
    .empty    (iq_empty),
    .count    (iq_cnt)
  );

  ifu_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pend_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.redirect),
    .push     (grant),
    .push_dat (fetch_pc_q),
    .pop      (rsp_keep),
    .pop_dat  (pq_head),
    .full     (pq_full),
    .empty    (pq_empty),
    .count    (pq_cnt)
  );

  logic unused_fifo;
  assign unused_fifo = ^{iq_full, pq_full, pq_empty, pq_cnt};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
`ifdef IFU_MISALIGN_TRAP_EN
    err_d      = err_q;
`endif
    if (grant) begin
      fetch_pc_d = fetch_pc_q + PC_INC;
      out_d      = out_d + CW'(1);
    end
    if (rsp) out_d = out_d - CW'(1);

    // Redirect wins: everything still in flight after this cycle gets dropped.
    if (bus.redirect) begin
      fetch_pc_d = tgt;
      drop_d     = out_d;
      state_d    = (out_d != '0) ? ST_FLUSH : ST_RUN;
`ifdef IFU_MISALIGN_TRAP_EN
      err_d      = tgt_bad;
      if (tgt_bad) state_d = ST_HALT;
`endif
    end else if (rsp && drop_q != '0) begin
      drop_d = drop_q - CW'(1);
      if (state_q == ST_FLUSH && drop_d == '0) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
`ifdef IFU_MISALIGN_TRAP_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
`ifdef IFU_MISALIGN_TRAP_EN
      err_q      <= err_d;
`endif
    end
  end

  rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rvalid |-> (out_q != '0));
endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: random-latency memory model plus a PC-stream scoreboard (expected stream restarts at each redirect target).
module tb_ifu;
  import ifu_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    int          rdy;
  } mem_ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ifu_if bus();

  ifu #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passed = 0;
  int          cyc;
  int          gnt_pct, rdy_pct, lat_lo, lat_hi;
  logic [31:0] key;
  logic [31:0] exp_fetch, exp_pc;
  bit          exp_halt;
  int          pops, grants, first_val_cyc;
  logic [31:0] last_pop_pc, last_gnt_addr;
  mem_ent_t    mem_q[$];

  // One cycle starting at a negedge: drive, sample at +1, score, advance to next negedge.
  task automatic step(input bit do_redir, input logic [31:0] tgt);
    logic exp_err;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    if (mem_q.size() > 0 && mem_q[0].rdy <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_q[0].addr ^ key;
    end
    bus.imem_gnt    = ($urandom_range(99) < gnt_pct);
    bus.id_ready    = ($urandom_range(99) < rdy_pct);
    bus.redirect    = do_redir;
    bus.redirect_pc = tgt;
    #1;
`ifdef IFU_MISALIGN_TRAP_EN
    exp_err = exp_halt;
`else
    exp_err = 1'b0;
`endif
    checks++;
    if (bus.misalign_err !== exp_err)
      $display("FAIL misalign_err cyc=%0d got %b expected %b", cyc, bus.misalign_err, exp_err);
    else passed++;
    if (do_redir || exp_halt) begin
      checks++;
      if ({bus.imem_req, bus.inst_val} !== 2'b00)
        $display("FAIL quiet_gate cyc=%0d req/val=%b expected 00", cyc, {bus.imem_req, bus.inst_val});
      else passed++;
    end
    if (bus.imem_req === 1'b1 && bus.imem_gnt) begin
      checks++;
      if (bus.imem_addr !== exp_fetch)
        $display("FAIL fetch_addr cyc=%0d got %h expected %h", cyc, bus.imem_addr, exp_fetch);
      else passed++;
      mem_q.push_back('{bus.imem_addr, cyc + $urandom_range(lat_hi, lat_lo)});
      exp_fetch     = exp_fetch + 32'd4;
      grants++;
      last_gnt_addr = bus.imem_addr;
    end
    if (bus.inst_val === 1'b1 && first_val_cyc < 0) first_val_cyc = cyc;
    if (bus.inst_val === 1'b1 && bus.id_ready) begin
      checks++;
      if (bus.inst_pc !== exp_pc || bus.inst !== (exp_pc ^ key))
        $display("FAIL inst_pop cyc=%0d got pc %h inst %h expected pc %h inst %h",
                 cyc, bus.inst_pc, bus.inst, exp_pc, exp_pc ^ key);
      else passed++;
      pops++;
      last_pop_pc = bus.inst_pc;
      exp_pc      = exp_pc + 32'd4;
    end
    if (bus.imem_rvalid) void'(mem_q.pop_front());
    if (do_redir) begin
`ifdef IFU_MISALIGN_TRAP_EN
      if (tgt[1:0] != 2'b00) exp_halt = 1'b1;
      else begin
        exp_halt  = 1'b0;
        exp_fetch = tgt;
        exp_pc    = tgt;
      end
`else
      exp_fetch = {tgt[31:2], 2'b00};
      exp_pc    = {tgt[31:2], 2'b00};
`endif
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    bus.id_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    checks += 6;
    if (bus.imem_req !== 1'b0)      $display("FAIL rst_req got %b expected 0", bus.imem_req); else passed++;
    if (bus.imem_addr !== 32'h0)    $display("FAIL rst_addr got %h expected 0", bus.imem_addr); else passed++;
    if (bus.inst !== 32'h0)         $display("FAIL rst_inst got %h expected 0", bus.inst); else passed++;
    if (bus.inst_pc !== 32'h0)      $display("FAIL rst_inst_pc got %h expected 0", bus.inst_pc); else passed++;
    if (bus.inst_val !== 1'b0)      $display("FAIL rst_inst_val got %b expected 0", bus.inst_val); else passed++;
    if (bus.misalign_err !== 1'b0)  $display("FAIL rst_misalign got %b expected 0", bus.misalign_err); else passed++;
    mem_q.delete();
    exp_fetch = 32'h0; exp_pc = 32'h0; exp_halt = 1'b0;
    cyc = 1; pops = 0; grants = 0; first_val_cyc = -1;
    rst = 1'b0;
  endtask

  task automatic test_stream();
    test_reset();
    gnt_pct = 100; rdy_pct = 100; lat_lo = 1; lat_hi = 1; key = 32'h0;
    repeat (30) step(1'b0, 32'h0);
    checks += 3;
    if (first_val_cyc !== 3) $display("FAIL first_valid got cycle %0d expected 3", first_val_cyc); else passed++;
    if (pops !== 28)         $display("FAIL stream_rate got %0d pops expected 28", pops); else passed++;
    if (last_pop_pc !== 32'h6C) $display("FAIL stream_last got %h expected 6c", last_pop_pc); else passed++;
  endtask

  task automatic test_backpressure();
    test_reset();
    gnt_pct = 100; rdy_pct = 0; lat_lo = 1; lat_hi = 1; key = 32'h0;
    repeat (10) step(1'b0, 32'h0);
    #1;
    checks += 3;
    if (grants !== DEPTH)       $display("FAIL bp_grants got %0d expected %0d", grants, DEPTH); else passed++;
    if (bus.imem_req !== 1'b0)  $display("FAIL bp_req got %b expected 0", bus.imem_req); else passed++;
    if (bus.inst_val !== 1'b1)  $display("FAIL bp_val got %b expected 1", bus.inst_val); else passed++;
    rdy_pct = 100;
    repeat (12) step(1'b0, 32'h0);
    checks += 2;
    if (pops !== 12)            $display("FAIL bp_resume got %0d pops expected 12", pops); else passed++;
    if (last_pop_pc !== 32'h2C) $display("FAIL bp_last got %h expected 2c", last_pop_pc); else passed++;
  endtask

  task automatic test_redirect();
    int p0;
    test_reset();
    gnt_pct = 100; rdy_pct = 100; lat_lo = 2; lat_hi = 2; key = 32'h1234_0000;
    repeat (8) step(1'b0, 32'h0);
    step(1'b1, 32'h100);
    p0 = pops;
    for (int k = 0; k < 20 && pops == p0; k++) step(1'b0, 32'h0);
    checks++;
    if (pops == p0 || last_pop_pc !== 32'h100)
      $display("FAIL redir_target got pc %h (pops %0d) expected 100", last_pop_pc, pops - p0);
    else passed++;
    lat_lo = 1; lat_hi = 1;
    repeat (6) step(1'b0, 32'h0);
    step(1'b1, 32'h340);
    p0 = pops;
    for (int k = 0; k < 20 && pops == p0; k++) step(1'b0, 32'h0);
    checks++;
    if (pops == p0 || last_pop_pc !== 32'h340)
      $display("FAIL redir_same_cycle got pc %h (pops %0d) expected 340", last_pop_pc, pops - p0);
    else passed++;
  endtask

  task automatic test_wrap();
    int g0;
    gnt_pct = 100; rdy_pct = 100; lat_lo = 1; lat_hi = 1;
    step(1'b1, 32'hFFFF_FFF8);
    g0 = grants;
    for (int k = 0; k < 20 && grants < g0 + 3; k++) step(1'b0, 32'h0);
    checks++;
    if (grants < g0 + 3 || last_gnt_addr !== 32'h0)
      $display("FAIL wrap_addr got %h expected 00000000", last_gnt_addr);
    else passed++;
    repeat (8) step(1'b0, 32'h0);
  endtask

  task automatic test_misalign();
    int g0;
    gnt_pct = 100; rdy_pct = 100; lat_lo = 1; lat_hi = 2;
    repeat (4) step(1'b0, 32'h0);
    step(1'b1, 32'h102);
`ifdef IFU_MISALIGN_TRAP_EN
    repeat (6) step(1'b0, 32'h0);
    #1;
    checks++;
    if (bus.misalign_err !== 1'b1 || bus.imem_req !== 1'b0)
      $display("FAIL halt_state got err %b req %b expected err 1 req 0", bus.misalign_err, bus.imem_req);
    else passed++;
    step(1'b1, 32'h200);
`endif
    g0 = grants;
    for (int k = 0; k < 20 && grants == g0; k++) step(1'b0, 32'h0);
    checks++;
`ifdef IFU_MISALIGN_TRAP_EN
    if (grants == g0 || last_gnt_addr !== 32'h200 || bus.misalign_err !== 1'b0)
      $display("FAIL halt_exit got addr %h err %b expected 200 err 0", last_gnt_addr, bus.misalign_err);
    else passed++;
`else
    if (grants == g0 || last_gnt_addr !== 32'h100)
      $display("FAIL misalign_forced got addr %h expected 100", last_gnt_addr);
    else passed++;
`endif
  endtask

  task automatic test_random();
    logic [31:0] t;
    gnt_pct = 75; rdy_pct = 70; lat_lo = 1; lat_hi = 3; key = 32'h5A5A_C3C3;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) test_reset();
      if ($urandom_range(99) < 4) begin
        t = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(99) < 15) t[1:0] = 2'($urandom_range(3, 1));
        step(1'b1, t);
      end else begin
        step(1'b0, 32'h0);
      end
    end
    step(1'b1, 32'h0000_0800);
    for (int k = 0; k < 40; k++) step(1'b0, 32'h0);
    checks++;
    if (last_pop_pc[31:8] !== 24'h000008)
      $display("FAIL random_recover got pc %h expected 000008xx", last_pop_pc);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_misalign();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
